// File: rtl/filter_pkg.sv
// Shared constants and types for the 3-parallel FIR filter and its serialiser.
package filter_pkg;

    localparam int unsigned NB  = 8;        // sample width
    localparam int unsigned NP  = 3;        // samples per parallel word
    localparam int unsigned WW  = NP * NB;  // parallel word width
    localparam int unsigned PHW = 2;        // phase counter width

    typedef logic [PHW-1:0] phase_t;

    localparam phase_t PH_FIRST = 2'd0;
    localparam phase_t PH_LAST  = 2'd2;

    // Parallel word layout: newest sample in the top bits.
    typedef struct packed {
        logic [NB-1:0] s2;
        logic [NB-1:0] s1;
        logic [NB-1:0] s0;
    } word_t;

endpackage

// File: rtl/filter_word_fifo.sv
// Synchronous word FIFO with push/pop, occupancy count and full/empty flags.
module filter_word_fifo #(
    parameter int unsigned W     = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of 2).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/filter_p2s.sv
// Re-serialises 3-sample filter words into a one-sample-per-cycle ready/valid stream.
module filter_p2s
    import filter_pkg::*;
#(
    parameter int unsigned NB    = filter_pkg::NB,
    parameter int unsigned DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [NB-1:0] DIN0,
    input  logic [NB-1:0] DIN1,
    input  logic [NB-1:0] DIN2,
    input  logic          VIN,
    input  logic          READY_OUT,
    output logic [NB-1:0] DOUT,
    output logic          VOUT,
    output logic          FULL,
    output logic          OVF,
    input  logic          CLR_OVF
);

    localparam int unsigned WWL = NP * NB;
    localparam int unsigned CW  = $clog2(DEPTH+1);

    logic [WWL-1:0] head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           push;
    logic           pop;
    logic           load;
    logic [NB-1:0]  sample_c;

    phase_t        phase_q, phase_d;
    logic [NB-1:0] dout_q,  dout_d;
    logic          vout_q,  vout_d;
    logic          ovf_q,   ovf_d;

    // Full decision uses the registered count, so a same-cycle pop never rescues a write.
    assign push = VIN && !fifo_full;
    assign load = (!vout_q || READY_OUT) && !fifo_empty;
    assign pop  = load && (phase_q == PH_LAST);

    filter_word_fifo #(
        .W     (WWL),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .pop   (pop),
        .wdata ({DIN2, DIN1, DIN0}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Pick the head sample addressed by the current phase.
    always_comb begin
        sample_c = head[NB-1:0];
        case (phase_q)
            2'd0:    sample_c = head[NB-1:0];
            2'd1:    sample_c = head[2*NB-1:NB];
            default: sample_c = head[3*NB-1:2*NB];
        endcase
    end

    // Next-state for phase, output register and sticky overflow.
    always_comb begin
        phase_d = phase_q;
        dout_d  = dout_q;
        vout_d  = vout_q;
        ovf_d   = ovf_q;
        if (load) begin
            dout_d  = sample_c;
            vout_d  = 1'b1;
            phase_d = (phase_q == PH_LAST) ? PH_FIRST : phase_q + PHW'(1);
        end else if (vout_q && READY_OUT) begin
            vout_d = 1'b0;
        end
        if (VIN && fifo_full) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset also abandons a partly sent word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_q <= PH_FIRST;
            dout_q  <= '0;
            vout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign DOUT = dout_q;
    assign VOUT = vout_q;
    assign FULL = fifo_full;
    assign OVF  = ovf_q;

    logic unused_ok;
    assign unused_ok = ^fifo_count;

endmodule

// File: tb/tb_filter_p2s.sv
// Directed self-checking bench for filter_p2s.
module tb_filter_p2s;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] DIN0, DIN1, DIN2;
    logic       VIN;
    logic       READY_OUT;
    logic [7:0] DOUT;
    logic       VOUT;
    logic       FULL;
    logic       OVF;
    logic       CLR_OVF;

    int total = 0;
    int bad   = 0;

    filter_p2s #(.NB(8), .DEPTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DIN0      (DIN0),
        .DIN1      (DIN1),
        .DIN2      (DIN2),
        .VIN       (VIN),
        .READY_OUT (READY_OUT),
        .DOUT      (DOUT),
        .VOUT      (VOUT),
        .FULL      (FULL),
        .OVF       (OVF),
        .CLR_OVF   (CLR_OVF)
    );

    always #5 CLK = ~CLK;

    // Advance one clock edge and settle before sampling or driving.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        DIN0 = a;
        DIN1 = b;
        DIN2 = c;
    endtask

    initial begin
        RST = 1'b1; VIN = 1'b1; READY_OUT = 1'b1; CLR_OVF = 1'b0;
        set_word(8'h11, 8'h22, 8'h33);

        // Reset held with VIN active
        tick(); tick();
        chk("rst_vout", 32'(VOUT), 32'd0);
        chk("rst_dout", 32'(DOUT), 32'h00);
        chk("rst_full", 32'(FULL), 32'd0);
        chk("rst_ovf",  32'(OVF),  32'd0);
        RST = 1'b0; VIN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", 32'(VOUT), 32'd0);
        end

        // Single word, free-flowing output
        set_word(8'h01, 8'hFE, 8'h03); VIN = 1'b1;
        tick(); VIN = 1'b0;
        chk("single_lat0", 32'(VOUT), 32'd0);
        tick(); chk("single_s0", 32'({VOUT, DOUT}), 32'h101);
        tick(); chk("single_s1", 32'({VOUT, DOUT}), 32'h1FE);
        tick(); chk("single_s2", 32'({VOUT, DOUT}), 32'h103);
        tick(); chk("single_end", 32'({VOUT, DOUT}), 32'h003);

        // Backpressure holds the first sample
        set_word(8'h01, 8'hFE, 8'h03); VIN = 1'b1;
        tick(); VIN = 1'b0;
        tick(); chk("bp_s0", 32'({VOUT, DOUT}), 32'h101);
        READY_OUT = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", 32'({VOUT, DOUT}), 32'h101);
        end
        READY_OUT = 1'b1;
        tick(); chk("bp_s1", 32'({VOUT, DOUT}), 32'h1FE);
        tick(); chk("bp_s2", 32'({VOUT, DOUT}), 32'h103);
        tick(); chk("bp_end", 32'(VOUT), 32'd0);

        // Fill to DEPTH then overflow
        READY_OUT = 1'b0;
        for (int w = 0; w < 5; w++) begin
            set_word(8'(3*w+1), 8'(3*w+2), 8'(3*w+3)); VIN = 1'b1;
            tick();
            if (w == 2) chk("fill_not_full3", 32'(FULL), 32'd0);
            if (w == 3) begin
                chk("fill_full4", 32'(FULL), 32'd1);
                chk("fill_no_ovf4", 32'(OVF), 32'd0);
            end
        end
        VIN = 1'b0;
        chk("ovf_set", 32'(OVF), 32'd1);
        chk("ovf_full", 32'(FULL), 32'd1);
        chk("ovf_head", 32'({VOUT, DOUT}), 32'h101);
        READY_OUT = 1'b1;
        for (int s = 2; s <= 12; s++) begin
            tick();
            chk("drain", 32'({VOUT, DOUT}), 32'h100 | 32'(s));
        end
        tick();
        chk("drain_end", 32'(VOUT), 32'd0);
        chk("drain_full", 32'(FULL), 32'd0);
        chk("ovf_sticky", 32'(OVF), 32'd1);
        CLR_OVF = 1'b1;
        tick(); CLR_OVF = 1'b0;
        chk("ovf_clr", 32'(OVF), 32'd0);

        // Sustained rate: one word every third cycle
        for (int c = 0; c < 33; c++) begin
            VIN = ((c % 3) == 0) && (c / 3 < 10);
            set_word(8'(c), 8'(c+1), 8'(c+2));
            tick();
            chk("rate_full", 32'(FULL), 32'd0);
            if (c >= 1 && c <= 30) chk("rate_data", 32'({VOUT, DOUT}), 32'h100 | 32'(c-1));
            if (c == 31) chk("rate_end", 32'(VOUT), 32'd0);
        end
        VIN = 1'b0;

        // Reset in the middle of a word
        set_word(8'h01, 8'hFE, 8'h03); VIN = 1'b1;
        tick(); VIN = 1'b0;
        tick(); chk("mid_s0", 32'({VOUT, DOUT}), 32'h101);
        tick(); chk("mid_s1", 32'({VOUT, DOUT}), 32'h1FE);
        RST = 1'b1;
        tick(); RST = 1'b0;
        chk("mid_rst_vout", 32'(VOUT), 32'd0);
        chk("mid_rst_dout", 32'(DOUT), 32'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_tail", 32'(VOUT), 32'd0);
        end
        set_word(8'h0A, 8'h0B, 8'h0C); VIN = 1'b1;
        tick(); VIN = 1'b0;
        tick(); chk("mid_w0", 32'({VOUT, DOUT}), 32'h10A);
        tick(); chk("mid_w1", 32'({VOUT, DOUT}), 32'h10B);
        tick(); chk("mid_w2", 32'({VOUT, DOUT}), 32'h10C);
        tick(); chk("mid_end", 32'(VOUT), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/filter_p2s.md
Name: filter_p2s

Overview:
Downstream stage of the 3-parallel FIR filter_top. It consumes the 3-sample output word (DOUT0/1/2 qualified by VOUT of the filter) and re-serialises it into a one-sample-per-cycle stream with ready/valid backpressure. A small word FIFO absorbs bursts. Dropped words are flagged, never silently lost.

Parameters:
NB, 8, sample width in bits (matches filter NB)
DEPTH, 4, FIFO depth in 3-sample words (power of 2, >=2)

Ports:
CLK  input  1  clock, all state updates on posedge
RST  input  1  synchronous reset, active-high
DIN0  input  NB  oldest sample of parallel word (x[3k])
DIN1  input  NB  middle sample (x[3k+1])
DIN2  input  NB  newest sample (x[3k+2])
VIN  input  1  DIN0..2 valid this cycle (driven from filter VOUT)
READY_OUT  input  1  downstream accepts DOUT this cycle
DOUT  output  NB  serial sample, registered
VOUT  output  1  DOUT valid, registered
FULL  output  1  FIFO holds DEPTH words
OVF  output  1  sticky overflow flag
CLR_OVF  input  1  clears OVF

Behaviour:
- Reset (sync, RST=1 at posedge): FIFO pointers/count=0, phase=0, DOUT=0, VOUT=0, FULL=0, OVF=0. VIN and READY_OUT are ignored while RST=1. Reset mid-word discards the FIFO contents and the partially emitted word.
- Write: at posedge with VIN=1 and FULL=0, push {DIN2,DIN1,DIN0} and increment count.
- Write while full: if VIN=1 and FULL=1, drop the word and set OVF=1. This holds even if a pop happens in the same cycle; the decision uses the registered FULL.
- Output register: load enable = (VOUT=0 or READY_OUT=1) and FIFO not empty. On load, DOUT <= head[phase] and VOUT <= 1.
- Output register with no load: if VOUT=1 and READY_OUT=1 and the FIFO is empty, VOUT <= 0 (DOUT holds its last value). If VOUT=1 and READY_OUT=0, DOUT and VOUT hold.
- Phase counter (0,1,2): advances on each load. On the load with phase=2, phase <= 0 and the head word is popped (count decrements). The head word stays in the FIFO and counts toward FULL until its DIN2 sample is loaded.
- Output order: DIN0, DIN1, DIN2 of word k, then DIN0 of word k+1. Data passes through bit-exact, with no sign handling or arithmetic.
- Latency: a word written at edge t gives DOUT=DIN0 with VOUT=1 after edge t+1, provided the output register is free.
- Throughput: one sample per cycle maximum. Sustained VIN every 3rd cycle with READY_OUT=1 never fills the FIFO, and VOUT stays 1 continuously once started.
- Simultaneous push and pop: count stays unchanged, pointers both advance.
- FULL = (count == DEPTH), derived from the registered count.
- OVF: set on a dropped word, cleared by CLR_OVF. If both happen in the same cycle, set wins.
- Count width is clog2(DEPTH+1). Pointers are clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package filter_pkg: NB=8, NP=3 (parallelism), word width NP*NB. filter_top and this block both use it.
- One sub-module, filter_word_fifo: synchronous FIFO, DEPTH x (NP*NB) bits, with push/pop/full/empty/count and sync active-high reset.
- filter_p2s contains the phase counter, the output register and the OVF logic.

Test Plan:
- Reset: hold RST=1 for 2 cycles with VIN=1 and DIN=0x11/22/33 -> VOUT=0, DOUT=0x00, FULL=0, OVF=0. No output appears after release until a new VIN.
- Single word: DIN0=0x01, DIN1=0xFE, DIN2=0x03, VIN=1 at edge t, READY_OUT=1 -> DOUT=0x01/0xFE/0x03 with VOUT=1 after edges t+1/t+2/t+3, then VOUT=0.
- Backpressure: as the single-word case but READY_OUT=0 for 5 cycles after the first sample -> DOUT holds 0x01 and VOUT stays 1. On release, 0xFE then 0x03 follow with none lost.
- Fill/overflow: READY_OUT=0, push 5 consecutive words (samples 1..15) -> FULL=1 after the 4th push. The 5th word is dropped and OVF=1. With READY_OUT=1 the output is exactly 1..12 in order. A CLR_OVF pulse then gives OVF=0.
- Sustained rate: VIN every 3rd cycle, ramp data 0..29, READY_OUT=1 -> DOUT=0..29 on consecutive cycles with VOUT=1 throughout, and FULL never 1.
- Reset mid-word: assert RST for 1 cycle right after DOUT=0xFE is accepted -> VOUT=0 on the next cycle and 0x03 never appears. A following word 0x0A/0x0B/0x0C is output from 0x0A.
